// File: rtl/piposr_frame.sv
// ---------------------------------------------------------------------------
// piposr_frame
//
// Parallel-in / parallel-out shift register with frame tracking.
//
// A frame begins with a parallel load (ldin). It completes after WIDTH
// shifts. The completing edge raises a one-cycle done pulse. When AUTO_LATCH
// is set, that edge also copies the received word into dout. Shifts made
// outside a frame still move data, but they do not count toward a frame.
//
// Parameters
//   WIDTH       shift register width (2..32)
//   MSB_FIRST   0: shift right, si enters the MSB and so is the LSB
//               1: shift left,  si enters the LSB and so is the MSB
//   AUTO_LATCH  1: dout is updated automatically when a frame completes
//
// Ports
//   CK      clock; all state changes on the rising edge
//   rstn    asynchronous active-low reset
//   din     parallel load data
//   si      serial input bit
//   ldin    parallel load strobe (starts or restarts a frame)
//   shen    shift enable
//   ldout   manual strobe that latches the shift register into dout
//   dout    registered parallel output
//   so      serial output, taken combinationally from the shift register
//   busy    registered, high while a frame is in progress
//   done    registered, one-cycle frame-complete pulse
//   bitcnt  registered count of bits shifted in the current frame
// ---------------------------------------------------------------------------
module piposr_frame #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit AUTO_LATCH = 1'b1
) (
  input  logic                       CK,
  input  logic                       rstn,
  input  logic [WIDTH-1:0]           din,
  input  logic                       si,
  input  logic                       ldin,
  input  logic                       shen,
  input  logic                       ldout,
  output logic [WIDTH-1:0]           dout,
  output logic                       so,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] bitcnt
);

  localparam int CW = $clog2(WIDTH + 1);

  // Count value just before the completing shift.
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_r, state_d;
  logic [WIDTH-1:0]  data_r,  data_d;
  logic [WIDTH-1:0]  dout_r,  dout_d;
  logic [CW-1:0]     cnt_r,   cnt_d;
  logic              busy_r;
  logic              done_r,  done_d;
  logic [WIDTH-1:0]  shifted;

  // The register contents after one shift step in the configured direction.
  always_comb begin
    shifted = data_r;
    if (MSB_FIRST) begin
      shifted = {data_r[WIDTH-2:0], si};
    end else begin
      shifted = {si, data_r[WIDTH-1:1]};
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_r;
    data_d  = data_r;
    dout_d  = dout_r;
    cnt_d   = cnt_r;
    done_d  = 1'b0;

    // The manual latch captures the pre-edge register value. The auto-latch
    // assignment below comes later in this block, so it overrides the manual
    // latch when the two happen on the same edge.
    if (ldout) begin
      dout_d = data_r;
    end

    if (ldin) begin
      // A load starts a frame from any state. If a frame is already in
      // progress, it is dropped without a done pulse.
      data_d  = din;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (shen) begin
      data_d = shifted;
      // Shifts outside a frame are free-running. They leave the counter,
      // busy and done untouched.
      if (state_r == SHIFT) begin
        cnt_d = cnt_r + CW'(1);
        if (cnt_r == LAST_CNT) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (AUTO_LATCH) begin
            dout_d = shifted;
          end
        end
      end
    end
  end

  // State register. busy is registered from the next state, so it always
  // matches the state register.
  always_ff @(posedge CK or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_d;
      busy_r  <= (state_d == SHIFT);
      done_r  <= done_d;
      cnt_r   <= cnt_d;
    end
  end

  // Shift register and output latch. Both are cleared by reset, so so and
  // dout read zero as soon as rstn falls.
  always_ff @(posedge CK or negedge rstn) begin
    if (!rstn) begin
      data_r <= '0;
      dout_r <= '0;
    end else begin
      data_r <= data_d;
      dout_r <= dout_d;
    end
  end

  assign so     = MSB_FIRST ? data_r[WIDTH-1] : data_r[0];
  assign dout   = dout_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign bitcnt = cnt_r;

endmodule

// File: doc/piposr_frame.md
PIPOSR_FRAME -- requirements
Module: piposr_frame

Interface
REQ-001 Parameter WIDTH, default 8: shift register width; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 0: 0 = shift right (si enters MSB, so = LSB); 1 = shift left (si enters LSB, so = MSB).
REQ-003 Parameter AUTO_LATCH, default 1: 1 = dout is updated automatically at frame completion.
REQ-004 CK  input  1  sole clock; all state changes on posedge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 din  input  WIDTH  parallel load data.
REQ-007 si  input  1  serial input bit.
REQ-008 ldin  input  1  parallel load strobe.
REQ-009 shen  input  1  shift enable.
REQ-010 ldout  input  1  manual parallel-output latch strobe.
REQ-011 dout  output  WIDTH  registered parallel output.
REQ-012 so  output  1  serial output, combinational from the shift register.
REQ-013 busy  output  1  registered; high while state = SHIFT.
REQ-014 done  output  1  registered; one-cycle frame-complete pulse.
REQ-015 bitcnt  output  $clog2(WIDTH+1)  registered count of bits shifted in the current frame.

Function
REQ-016 The block SHALL hold an internal WIDTH-bit register data and a two-state FSM: IDLE and SHIFT.
REQ-017 so SHALL equal data[0] when MSB_FIRST=0 and data[WIDTH-1] when MSB_FIRST=1, with no register delay.
REQ-018 ldin=1 at an edge SHALL load data <= din, set bitcnt <= 0, and enter SHIFT from any state.
REQ-019 ldin SHALL have priority over shen; no shift occurs on a load edge.
REQ-020 ldin=0 and shen=1 at an edge SHALL shift data one position in the MSB_FIRST direction, inserting si; shen=0 SHALL hold data.
REQ-021 Shifts in IDLE SHALL modify data but SHALL NOT change bitcnt, busy or done (free-running mode).
REQ-022 Each shift in SHIFT SHALL increment bitcnt by 1.
REQ-023 The shift that brings bitcnt from WIDTH-1 to WIDTH SHALL complete the frame: on that edge state -> IDLE and done <= 1; on the next edge done <= 0 unless another frame completes.
REQ-024 bitcnt SHALL hold at WIDTH after frame completion until the next ldin; it SHALL never wrap.
REQ-025 ldin on the edge after completion SHALL start a new frame; there are no dead cycles between frames.
REQ-026 ldin during SHIFT SHALL abort the current frame without a done pulse and restart it with bitcnt = 0.
REQ-027 ldout=1 SHALL latch dout <= data using the pre-edge value of data, one edge of latency.
REQ-028 With AUTO_LATCH=1, the completing edge SHALL latch dout <= the post-shift value of data (the full received word).
REQ-029 If auto-latch and ldout coincide, auto-latch SHALL win.
REQ-030 With AUTO_LATCH=0, dout SHALL change only on ldout.
REQ-031 busy SHALL be 1 exactly when state = SHIFT.

Reset
REQ-032 rstn=0 SHALL immediately, without waiting for a clock edge, force data=0, dout=0, bitcnt=0, done=0, busy=0 and state=IDLE; so SHALL therefore read 0.
REQ-033 Reset asserted mid-frame SHALL discard the frame; no done pulse SHALL be generated after release.
REQ-034 After rstn deasserts, the first active edge SHALL operate normally.

Verification
REQ-035 WIDTH=4, MSB_FIRST=0: load din=4'b1011, then 4 shifts with si=0,1,1,0 -> so sequence before each shift = 1,1,0,1; done pulses on the 4th shift edge; dout=4'b0110; busy falls on the same edge.
REQ-036 WIDTH=8, MSB_FIRST=1: load 8'hA5, 8 shifts with si=1 -> so sequence = 1,0,1,0,0,1,0,1; final dout=8'hFF; bitcnt=8 and held.
REQ-037 WIDTH=8: ldin and shen asserted together with din=8'h3C -> data=8'h3C, bitcnt=0, no shift; a subsequent ldin after 3 shifts -> bitcnt=0, no done pulse.
REQ-038 AUTO_LATCH=0, WIDTH=4: frame completes -> dout unchanged (0); ldout on the next edge -> dout = the received word.
REQ-039 rstn pulsed low between clock edges at bitcnt=5 (WIDTH=8) -> all outputs are 0 immediately; no done pulse after release.
REQ-040 IDLE with shen=1 and si=1 for 3 edges (WIDTH=4, data=0, right shift) -> data=4'b1110; bitcnt, busy and done remain 0.
